// File: rtl/cfg_chain_loader_pkg.sv
// Shared types and derived sizing helpers for the fabric programming chain loader.
package cfg_chain_loader_pkg;

  typedef enum logic {
    CFG_LOAD   = 1'b0,
    CFG_VERIFY = 1'b1
  } cfg_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_FINISH   = 3'd4
  } cfg_state_e;

  function automatic int shifts_per_word(input int data_w, input int num_chains);
    return data_w / num_chains;
  endfunction

  function automatic int words_per_pass(input int chain_len, input int num_chains, input int data_w);
    return (chain_len * num_chains) / data_w;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cfg_chain_loader_prog_clk_gen.sv
// Divides clk into a registered prog_clk with HALF_PER-cycle phases; strobes the last cycle of each phase.
// Held low with its phase counter cleared whenever i_en is low, so stalls never produce an edge.
module cfg_chain_loader_prog_clk_gen
  import cfg_chain_loader_pkg::*;
#(
  parameter int HALF_PER = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_prog_clk,
  output logic o_lo_last,
  output logic o_hi_last
);

  localparam int C_W = cnt_w(HALF_PER);

  logic [C_W-1:0] r_cnt;
  logic           r_prog_clk;
  logic           w_phase_end;

  assign w_phase_end = (r_cnt == C_W'(HALF_PER - 1));
  assign o_lo_last   = i_en && !r_prog_clk && w_phase_end;
  assign o_hi_last   = i_en &&  r_prog_clk && w_phase_end;
  assign o_prog_clk  = r_prog_clk;

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      r_cnt      <= '0;
      r_prog_clk <= 1'b0;
    end else if (w_phase_end) begin
      r_cnt      <= '0;
      r_prog_clk <= ~r_prog_clk;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cfg_chain_loader.sv
// Serialises a valid/ready bitstream onto NUM_CHAINS programming chains, one bit per 2*HALF_PER clk.
// VERIFY re-shifts the stream and counts prog_out/prog_in disagreements; s_ready only in FETCH.
module cfg_chain_loader
  import cfg_chain_loader_pkg::*;
#(
  parameter int NUM_CHAINS = 1,
  parameter int CHAIN_LEN  = 125,
  parameter int DATA_W     = 8,
  parameter int HALF_PER   = 2,
  localparam int MCNT_W    = $clog2(CHAIN_LEN * NUM_CHAINS + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_mode,
  input  logic [DATA_W-1:0]     i_s_data,
  input  logic                  i_s_valid,
  output logic                  o_s_ready,
  output logic [NUM_CHAINS-1:0] o_prog_in,
  output logic                  o_prog_clk,
  output logic                  o_prog_en,
  input  logic [NUM_CHAINS-1:0] i_prog_out,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [MCNT_W-1:0]     o_mismatch_cnt
);

  localparam int SPW = shifts_per_word(DATA_W, NUM_CHAINS);
  localparam int K_W = cnt_w(SPW);
  localparam int T_W = cnt_w(CHAIN_LEN);

  cfg_state_e            r_state;
  cfg_state_e            w_state_nxt;
  cfg_mode_e             r_mode;
  logic [DATA_W-1:0]     r_buf;
  logic [NUM_CHAINS-1:0] r_prog_in;
  logic [K_W-1:0]        r_k;
  logic [T_W-1:0]        r_total;
  logic [MCNT_W-1:0]     r_mcnt;

  logic                  w_clk_en;
  logic                  w_lo_last;
  logic                  w_hi_last;
  logic                  w_last_shift;
  logic                  w_word_end;
  logic [DATA_W-1:0]     w_buf_nxt;
  logic [NUM_CHAINS-1:0] w_miss;
  logic [MCNT_W-1:0]     w_miss_cnt;

  cfg_chain_loader_prog_clk_gen #(
    .HALF_PER (HALF_PER)
  ) u_prog_clk_gen (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_en       (w_clk_en),
    .o_prog_clk (o_prog_clk),
    .o_lo_last  (w_lo_last),
    .o_hi_last  (w_hi_last)
  );

  assign w_last_shift   = (r_total == T_W'(CHAIN_LEN - 1));
  assign w_word_end     = (r_k == K_W'(SPW - 1));
  assign w_buf_nxt      = r_buf >> NUM_CHAINS;
  assign w_miss         = i_prog_out ^ r_prog_in;
  assign o_prog_in      = r_prog_in;
  assign o_mismatch_cnt = r_mcnt;

  always_comb begin
    w_miss_cnt = '0;
    for (int c = 0; c < NUM_CHAINS; c++) begin
      w_miss_cnt = w_miss_cnt + MCNT_W'(w_miss[c]);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_s_ready   = 1'b0;
    o_prog_en   = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    w_clk_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        o_s_ready = 1'b1;
        o_prog_en = 1'b1;
        o_busy    = 1'b1;
        if (i_s_valid) w_state_nxt = ST_SHIFT_LO;
      end
      ST_SHIFT_LO: begin
        o_prog_en = 1'b1;
        o_busy    = 1'b1;
        w_clk_en  = 1'b1;
        if (w_lo_last) w_state_nxt = ST_SHIFT_HI;
      end
      ST_SHIFT_HI: begin
        o_prog_en = 1'b1;
        o_busy    = 1'b1;
        w_clk_en  = 1'b1;
        if (w_hi_last) begin
          if (w_last_shift)    w_state_nxt = ST_FINISH;
          else if (w_word_end) w_state_nxt = ST_FETCH;
          else                 w_state_nxt = ST_SHIFT_LO;
        end
      end
      ST_FINISH: begin
        o_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_mode    <= CFG_LOAD;
      r_buf     <= '0;
      r_prog_in <= '0;
      r_k       <= '0;
      r_total   <= '0;
      r_mcnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && i_start) begin
        r_mode  <= cfg_mode_e'(i_mode);
        r_mcnt  <= '0;
        r_total <= '0;
      end
      // prog_in is updated on entry to SHIFT_LO so it is stable across the whole bit period.
      if (r_state == ST_FETCH && i_s_valid) begin
        r_buf     <= i_s_data;
        r_prog_in <= i_s_data[NUM_CHAINS-1:0];
        r_k       <= '0;
      end
      if (r_state == ST_SHIFT_LO && w_lo_last && r_mode == CFG_VERIFY) begin
        r_mcnt <= r_mcnt + w_miss_cnt;
      end
      if (r_state == ST_SHIFT_HI && w_hi_last) begin
        r_total <= r_total + 1'b1;
        r_k     <= r_k + 1'b1;
        if (!w_word_end) begin
          r_buf     <= w_buf_nxt;
          r_prog_in <= w_buf_nxt[NUM_CHAINS-1:0];
        end
      end
    end
  end

endmodule
